// File: rtl/mul_pipe_pkg.sv
// Shared definitions for the pipelined radix-4 Booth / Wallace multiplier.
//   npp(width)   : number of Booth partial products for a width-bit operand
//   pw(width)    : product width (2*width)
//   booth_digit_e: Booth digit codes; bit 2 set means the row is negated
//   booth_encode : maps a 3-bit multiplier window to its Booth digit
package mul_pipe_pkg;

  typedef enum logic [2:0] {
    ZERO = 3'b000,
    POS1 = 3'b001,
    POS2 = 3'b010,
    NEG1 = 3'b101,
    NEG2 = 3'b110
  } booth_digit_e;

  function automatic int unsigned npp(input int unsigned width);
    return (width + 2) / 2;
  endfunction

  function automatic int unsigned pw(input int unsigned width);
    return 2 * width;
  endfunction

  // Window is {b[2i+1], b[2i], b[2i-1]}
  function automatic booth_digit_e booth_encode(input logic [2:0] bits);
    booth_digit_e dig;
    dig = ZERO;
    case (bits)
      3'b001, 3'b010: dig = POS1;
      3'b011:         dig = POS2;
      3'b100:         dig = NEG2;
      3'b101, 3'b110: dig = NEG1;
      default:        dig = ZERO;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_wallace_tree.sv
// Combinational 3:2 carry-save reduction of Booth partial-product rows.
// Ports:
//   i_rows  : NPP rows of PW bits, row i at bits [i*PW +: PW], already shifted
//   i_neg   : per-row negate carry, weight 2^(2i)
//   o_sum   : sum vector
//   o_carry : carry vector; o_sum + (o_carry << 1) == sum of all inputs mod 2^PW
module booth_wallace_tree
  import mul_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [npp(WIDTH)*pw(WIDTH)-1:0] i_rows,
  input  logic [npp(WIDTH)-1:0]           i_neg,
  output logic [pw(WIDTH)-1:0]            o_sum,
  output logic [pw(WIDTH)-1:0]            o_carry
);

  localparam int unsigned NPP   = npp(WIDTH);
  localparam int unsigned PW    = pw(WIDTH);
  localparam int unsigned NROWS = NPP + 1;

  // Negate carries sit at bit 2i, which is below every row that starts at 2i,
  // so they pack into one sparse extra row.
  logic [PW-1:0] w_neg_row;

  always_comb begin
    w_neg_row = '0;
    for (int i = 0; i < int'(NPP); i++) begin
      w_neg_row[2*i] = i_neg[i];
    end
  end

  // Level-by-level 3:2 compression down to three rows, then one final 3:2
  // whose carry is left unshifted for the output.
  always_comb begin
    logic [PW-1:0] cur [NROWS];
    logic [PW-1:0] nxt [NROWS];
    logic [PW-1:0] a;
    logic [PW-1:0] b;
    logic [PW-1:0] c;
    int            cnt;
    int            ncnt;
    int            base;

    cur  = '{default: '0};
    nxt  = '{default: '0};
    a    = '0;
    b    = '0;
    c    = '0;
    cnt  = int'(NROWS);
    ncnt = 0;
    base = 0;

    for (int r = 0; r < int'(NPP); r++) begin
      cur[r] = i_rows[r*PW +: PW];
    end
    cur[NROWS-1] = w_neg_row;

    for (int lvl = 0; lvl < int'(NROWS); lvl++) begin
      if (cnt > 3) begin
        nxt  = '{default: '0};
        ncnt = 0;
        base = (cnt / 3) * 3;
        for (int g = 0; g < int'(NROWS / 3); g++) begin
          if (3*g + 2 < cnt) begin
            a = cur[3*g];
            b = cur[3*g + 1];
            c = cur[3*g + 2];
            nxt[ncnt]     = a ^ b ^ c;
            nxt[ncnt + 1] = ((a & b) | (a & c) | (b & c)) << 1;
            ncnt = ncnt + 2;
          end
        end
        // Rows left over from an incomplete group pass straight through
        for (int r = 0; r < int'(NROWS); r++) begin
          if (r >= base && r < cnt) begin
            nxt[ncnt] = cur[r];
            ncnt = ncnt + 1;
          end
        end
        cur = nxt;
        cnt = ncnt;
      end
    end

    a       = cur[0];
    b       = cur[1];
    c       = cur[2];
    o_sum   = a ^ b ^ c;
    o_carry = (a & b) | (a & c) | (b & c);
  end

endmodule

// File: rtl/booth_wallace_mul_pipe.sv
// Three-stage pipelined radix-4 Booth multiplier with Wallace reduction,
// per-transaction signed/unsigned mode, tag passthrough and valid/ready flow.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : operand handshake (in_ready combinational)
//   in_a, in_b            : multiplicand, multiplier
//   in_signed             : 1 = two's-complement operands, 0 = unsigned
//   in_tag                : opaque tag returned with the result
//   out_valid/out_ready   : result handshake
//   out_product, out_tag  : full-width product and its tag (registered)
module booth_wallace_mul_pipe
  import mul_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic                   in_signed,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [pw(WIDTH)-1:0]   out_product,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int unsigned NPP = npp(WIDTH);
  localparam int unsigned PW  = pw(WIDTH);
  localparam int unsigned XW  = WIDTH + 2;

  // Stage registers
  logic                r_s1_valid;
  logic [NPP*PW-1:0]   r_s1_rows;
  logic [NPP-1:0]      r_s1_neg;
  logic [TAG_W-1:0]    r_s1_tag;
  logic                r_s2_valid;
  logic [PW-1:0]       r_s2_sum;
  logic [PW-1:0]       r_s2_carry;
  logic [TAG_W-1:0]    r_s2_tag;
  logic                r_out_valid;
  logic [PW-1:0]       r_out_product;
  logic [TAG_W-1:0]    r_out_tag;

  logic                w_s1_ready;
  logic                w_s2_ready;
  logic                w_s3_ready;
  logic [XW-1:0]       w_a_ext;
  logic [XW-1:0]       w_b_ext;
  logic [XW:0]         w_b_win;
  logic [NPP*PW-1:0]   w_rows;
  logic [NPP-1:0]      w_neg;
  logic [PW-1:0]       w_tree_sum;
  logic [PW-1:0]       w_tree_carry;
  logic [PW-1:0]       w_final;

  // Ready chain: a stage may load when empty or when it drains this cycle
  assign w_s3_ready = !r_out_valid || out_ready;
  assign w_s2_ready = !r_s2_valid  || w_s3_ready;
  assign w_s1_ready = !r_s1_valid  || w_s2_ready;
  assign in_ready   = rst_n && w_s1_ready;

  // Two extra bits make every operand representable as signed, and hold 2A
  assign w_a_ext = in_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
  assign w_b_ext = in_signed ? {{2{in_b[WIDTH-1]}}, in_b} : {2'b00, in_b};
  assign w_b_win = {w_b_ext, 1'b0};

  // Booth partial products: one's-complement rows plus a separate +1 carry
  always_comb begin
    booth_digit_e  dig;
    logic [XW-1:0] mag;
    dig    = ZERO;
    mag    = '0;
    w_rows = '0;
    w_neg  = '0;
    for (int i = 0; i < int'(NPP); i++) begin
      dig = booth_encode(w_b_win[2*i +: 3]);
      case (dig)
        POS1:    mag = w_a_ext;
        POS2:    mag = w_a_ext << 1;
        NEG1:    mag = ~w_a_ext;
        NEG2:    mag = ~(w_a_ext << 1);
        default: mag = '0;
      endcase
      w_neg[i] = dig[2];
      w_rows[i*PW +: PW] = {{(PW-XW){mag[XW-1]}}, mag} << (2*i);
    end
  end

  // S1 valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_ready) begin
      r_s1_valid <= in_valid;
    end
  end

  // S1 data
  always_ff @(posedge clk) begin
    if (w_s1_ready && in_valid) begin
      r_s1_rows <= w_rows;
      r_s1_neg  <= w_neg;
      r_s1_tag  <= in_tag;
    end
  end

  booth_wallace_tree #(
    .WIDTH (WIDTH)
  ) u_tree (
    .i_rows  (r_s1_rows),
    .i_neg   (r_s1_neg),
    .o_sum   (w_tree_sum),
    .o_carry (w_tree_carry)
  );

  // S2 valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
    end
  end

  // S2 data
  always_ff @(posedge clk) begin
    if (w_s2_ready && r_s1_valid) begin
      r_s2_sum   <= w_tree_sum;
      r_s2_carry <= w_tree_carry;
      r_s2_tag   <= r_s1_tag;
    end
  end

  // Final carry-propagate add
  assign w_final = r_s2_sum + (r_s2_carry << 1);

  // S3 output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_product <= '0;
      r_out_tag     <= '0;
    end else if (w_s3_ready) begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_product <= w_final;
        r_out_tag     <= r_s2_tag;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_product = r_out_product;
  assign out_tag     = r_out_tag;

endmodule

// File: tb/tb_booth_wallace_mul_pipe.sv
// Self-checking bench for booth_wallace_mul_pipe (WIDTH=16, TAG_W=4).
module tb_booth_wallace_mul_pipe;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned TAG_W = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic              in_signed;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_product;
  logic [TAG_W-1:0]  out_tag;

  int n_tests = 0;
  int n_fail  = 0;

  booth_wallace_mul_pipe #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_signed   (in_signed),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_tag     (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    if (s) begin
      sa = {{16{a[15]}}, a};
      sb = {{16{b[15]}}, b};
      return 32'(sa * sb);
    end
    return {16'b0, a} * {16'b0, b};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // One transaction into an empty pipe with out_ready high; starts at a negedge
  task automatic run_single(input string nm, input logic [15:0] a, input logic [15:0] b,
                            input logic s, input logic [3:0] tag, input logic [31:0] exp);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_tag    = tag;
    out_ready = 1'b1;
    #1;
    check_eq({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check_eq({nm, "_lat1_valid"}, 64'(out_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    check_eq({nm, "_lat2_valid"}, 64'(out_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    check_eq({nm, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({nm, "_product"}, 64'(out_product), 64'(exp));
    check_eq({nm, "_tag"}, 64'(out_tag), 64'(tag));
    @(posedge clk); @(negedge clk);
    check_eq({nm, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_backpressure();
    out_ready = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      in_valid  = 1'b1;
      in_a      = 16'(t);
      in_b      = 16'h1000;
      in_signed = 1'b0;
      in_tag    = 4'(t);
      #1;
      check_eq($sformatf("bp_in_ready_t%0d", t), 64'(in_ready), 64'(t < 4));
      if (t < 4) begin
        @(posedge clk); @(negedge clk);
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      #1;
      check_eq("bp_hold_valid", 64'(out_valid), 64'd1);
      check_eq("bp_hold_product", 64'(out_product), 64'h0000_1000);
      check_eq("bp_hold_tag", 64'(out_tag), 64'd1);
      check_eq("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      check_eq($sformatf("bp_drain_valid_%0d", k), 64'(out_valid), 64'd1);
      check_eq($sformatf("bp_drain_tag_%0d", k), 64'(out_tag), 64'(k));
      check_eq($sformatf("bp_drain_product_%0d", k), 64'(out_product), 64'(32'(k) << 12));
      @(posedge clk); @(negedge clk);
    end
    check_eq("bp_empty", 64'(out_valid), 64'd0);
  endtask

  task automatic run_stream();
    logic [35:0] q[$];
    logic [35:0] e;
    int          sent;
    int          rcvd;
    int          cyc;
    logic        acc;
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    in_valid = 1'b0;
    while ((sent < 200 || rcvd < 200) && cyc < 5000) begin
      if (!in_valid && sent < 200 && $urandom_range(0, 1) == 1) begin
        in_valid  = 1'b1;
        in_a      = pick();
        in_b      = pick();
        in_signed = 1'($urandom_range(0, 1));
        in_tag    = 4'(sent);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      if (acc) begin
        q.push_back({in_tag, ref_mul(in_a, in_b, in_signed)});
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check_eq("stream_spurious_out", 64'(out_valid), 64'd0);
        end else begin
          e = q.pop_front();
          check_eq($sformatf("stream_product_%0d", rcvd), 64'(out_product), 64'(e[31:0]));
          check_eq($sformatf("stream_tag_%0d", rcvd), 64'(out_tag), 64'(e[35:32]));
        end
        rcvd++;
      end
      @(posedge clk); @(negedge clk);
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    check_eq("stream_sent", 64'(sent), 64'd200);
    check_eq("stream_rcvd", 64'(rcvd), 64'd200);
    check_eq("stream_leftover", 64'(q.size()), 64'd0);
  endtask

  task automatic run_reset_mid();
    out_ready = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      in_valid  = 1'b1;
      in_a      = 16'(t + 20);
      in_b      = 16'(t + 30);
      in_signed = 1'b0;
      in_tag    = 4'(t);
      @(posedge clk); @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_eq("rst_mid_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); @(negedge clk);
    check_eq("rst_mid_valid", 64'(out_valid), 64'd0);
    check_eq("rst_mid_product", 64'(out_product), 64'd0);
    check_eq("rst_mid_tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_release_in_ready", 64'(in_ready), 64'd1);
    run_single("rst_first", 16'd7, 16'd9, 1'b0, 4'hA, 32'h0000_003F);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_signed = 1'b0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_out_valid", 64'(out_valid), 64'd0);
    check_eq("reset_out_product", 64'(out_product), 64'd0);
    check_eq("reset_out_tag", 64'(out_tag), 64'd0);
    check_eq("reset_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    check_eq("release_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    run_single("s_m3x5",         16'hFFFD, 16'h0005, 1'b1, 4'h3, 32'hFFFF_FFF1);
    run_single("u_ffffxffff",    16'hFFFF, 16'hFFFF, 1'b0, 4'h4, 32'hFFFE_0001);
    run_single("s_ffffxffff",    16'hFFFF, 16'hFFFF, 1'b1, 4'h5, 32'h0000_0001);
    run_single("s_8000x8000",    16'h8000, 16'h8000, 1'b1, 4'h6, 32'h4000_0000);
    run_single("u_8000x8000",    16'h8000, 16'h8000, 1'b0, 4'h7, 32'h4000_0000);
    run_single("u_8000x7fff",    16'h8000, 16'h7FFF, 1'b0, 4'h8, 32'h3FFF_8000);
    run_single("s_7fffx8000",    16'h7FFF, 16'h8000, 1'b1, 4'h9, 32'hC000_8000);
    run_single("s_1234x0",       16'h1234, 16'h0000, 1'b1, 4'hB, 32'h0000_0000);

    run_backpressure();
    run_stream();
    run_reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/booth_wallace_mul_pipe.md
Name: booth_wallace_mul_pipe

Overview:
- Parametrised, pipelined radix-4 Booth multiplier.
- Core datapath: a Booth partial-product generator, a Wallace reduction tree to two rows, and a final carry-propagate adder.
- Extends the fixed 8-row/32-bit reduction block with configurable operand width, per-transaction signed/unsigned mode, a tag passthrough, and valid/ready flow control with backpressure.
- Sits between the execute-stage operand registers and the writeback arbiter.

Parameters:
- WIDTH, 16, operand width in bits; must be even and at least 4; product width is 2*WIDTH.
- TAG_W, 4, width of the opaque tag carried alongside each transaction.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand transaction valid
- in_ready  output  1  block can accept a transaction this cycle
- in_a  input  WIDTH  multiplicand
- in_b  input  WIDTH  multiplier
- in_signed  input  1  1: two's-complement operands; 0: unsigned
- in_tag  input  TAG_W  tag; returned unchanged with the result
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_product  output  2*WIDTH  a*b, exact, full width
- out_tag  output  TAG_W  tag of this result

Behaviour:
- Reset: on a clk edge with rst_n=0, all stage valid flags clear, out_valid=0, out_product=0, out_tag=0. in_ready is 0 while rst_n=0 and 1 in the first cycle after release.
- Transfers: a transfer occurs on an edge where valid and ready are both 1. This rule applies independently at the input and output sides.
- Stage S1 (Booth encode):
  - Extend both operands to WIDTH+2 bits: sign-extend if in_signed=1, zero-extend otherwise.
  - Generate NPP=(WIDTH+2)/2 radix-4 Booth partial products, each in {0, +-A, +-2A}.
  - Each partial product carries a separate negate-carry bit. Rows are sign-extended to 2*WIDTH and shifted by 2*i.
  - Register the rows, carry bits, tag and valid.
- Stage S2 (reduction):
  - A 3:2 carry-save Wallace tree reduces the NPP rows plus negate-carry bits to sum and carry vectors of 2*WIDTH bits.
  - Inject leftover carry bits into free LSB positions, as the fixed 8-row tree does.
  - Register the two vectors, tag and valid.
- Stage S3 (final add):
  - out_product = sum + (carry<<1), modulo 2^(2*WIDTH).
  - The result is registered into out_product/out_tag together with out_valid.
- Latency: exactly 3 cycles from input transfer to out_valid when out_ready is held high. Throughput is 1 result per cycle.
- Backpressure:
  - Each stage register loads when it is empty or when its contents move forward in the same cycle.
  - in_ready = !S1_valid OR S1 advances. The ready chain is combinational from out_ready back to in_ready.
  - Capacity is 3 transactions. When all stages are full and out_ready=0, in_ready=0.
- Stability: while out_valid=1 and out_ready=0, out_product and out_tag hold stable.
- Simultaneous events: a transfer out and a transfer in on the same edge with the pipe full is a legal, lossless, full-rate case.
- Ordering: results leave in acceptance order. No transaction is dropped or duplicated.
- Bubbles: a stage that is invalid does not need to clear its data; output data is don't-care while out_valid=0.
- Arithmetic:
  - Signed mode: the result equals the signed 2*WIDTH product, which always fits (e.g. -2^(W-1) * -2^(W-1) = 2^(2W-2)).
  - Unsigned mode: the result equals the unsigned product.
- Reset mid-operation: all in-flight transactions are discarded and none is emitted after reset.

Decomposition:
- Package mul_pipe_pkg holds:
  - the function npp(WIDTH) = (WIDTH+2)/2;
  - Booth digit encodings (ZERO, POS1, POS2, NEG1, NEG2);
  - the width helper PW = 2*WIDTH.
- Sub-module booth_wallace_tree: purely combinational, parametrised by WIDTH. Input is a flattened NPP x 2*WIDTH row array plus a carry vector; outputs are the sum and carry vectors.
  - Instantiated once, between S1 and S2.
  - Verifiable standalone against a behavioural sum of its rows.
- Booth encoding and the final adder stay in the top module.

Test Plan:
- WIDTH=16, signed, a=0xFFFD (-3), b=0x0005, out_ready=1 -> after 3 cycles out_product=0xFFFFFFF1 with the input tag.
- Unsigned, a=0xFFFF, b=0xFFFF -> 0xFFFE0001. Same operands with signed=1 -> 0x00000001.
- Signed, a=b=0x8000 -> 0x40000000. Unsigned, a=b=0x8000 -> 0x40000000. Unsigned, a=0x8000, b=0x7FFF -> 0x3FFF8000.
- Backpressure:
  - Hold out_ready=0 and offer tags 1,2,3,4 back-to-back -> 3 are accepted and in_ready=0 while tag 4 is offered.
  - out_product/out_tag stay stable for 5 cycles.
  - Raise out_ready -> tags 1,2,3,4 emerge in order on consecutive cycles.
- Full-rate stream: 200 random transactions with random signed mode, random out_ready toggling and 50% in_valid -> every result matches the reference model, in order, with no loss.
- Reset: drive rst_n=0 with 3 in flight -> the next cycle has out_valid=0. After release, the first new transaction (7*9, tag 0xA) -> 0x0000003F, tag 0xA, exactly 3 cycles later, with no stale outputs.
